// File: rtl/kmkz_divide.sv
// rtl/kmkz_divide.sv - iterative restoring integer divider for the execute stage
//
// Purpose:
//   Executes RISC-V DIV/DIVU/REM/REMU with a restoring shift-subtract core
//   working on operand magnitudes. It retires STEPS_PER_CYCLE quotient bits
//   per clock, so an operation takes XLEN/STEPS_PER_CYCLE busy cycles. The
//   execute stage is held through the start cycle and every busy cycle. The
//   result is presented in DONE until the pipeline advances.
//
// Optional feature:
//   KMKZ_DIV_FAST_EN - when defined, three cases resolve in the start cycle
//   and go straight from IDLE to DONE: divisor zero, signed overflow, and a
//   dividend magnitude below the divisor magnitude.
//
// Ports:
//   clk_i          in   1     clock, rising edge
//   rst_i          in   1     asynchronous reset, active low
//   x_stall_i      in   1     execute-stage global stall (holds DONE)
//   x_kill_i       in   1     execute-stage flush (aborts BUSY/DONE)
//   d_valid_i      in   1     decode output valid
//   d_is_divide_i  in   1     instruction is DIV/DIVU/REM/REMU
//   d_fun_i        in   3     funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   d_rs1_i        in   XLEN  dividend
//   d_rs2_i        in   XLEN  divisor
//   x_stall_req_o  out  1     hold execute stage (combinational)
//   x_rd_o         out  XLEN  result (registered)
//   x_busy_o       out  1     FSM not IDLE

module kmkz_divide #(
  parameter int XLEN            = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            x_stall_i,
  input  logic            x_kill_i,
  input  logic            d_valid_i,
  input  logic            d_is_divide_i,
  input  logic [2:0]      d_fun_i,
  input  logic [XLEN-1:0] d_rs1_i,
  input  logic [XLEN-1:0] d_rs2_i,
  output logic            x_stall_req_o,
  output logic [XLEN-1:0] x_rd_o,
  output logic            x_busy_o
);

  localparam int N  = XLEN / STEPS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;   // partial remainder
  logic [XLEN-1:0] quo_q, quo_d;   // dividend bits shifting out, quotient bits in
  logic [XLEN-1:0] dvs_q, dvs_d;   // divisor magnitude
  logic [XLEN-1:0] rd_q, rd_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            dz_q, dz_d;
  logic            rsel_q, rsel_d;

  logic            start;
  logic            stall_req;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] rem_s, quo_s;
  logic [XLEN:0]   part, diff;
  logic [XLEN-1:0] q_fin, r_fin, fin_res;
  logic            fun_unused;

  // funct3[2] is implied by d_is_divide_i; only the unsigned and remainder
  // bits steer the datapath.
  assign fun_unused = d_fun_i[2];

  // Operand preparation for the start cycle. fun[0] set means unsigned.
  assign a_neg = ~d_fun_i[0] & d_rs1_i[XLEN-1];
  assign b_neg = ~d_fun_i[0] & d_rs2_i[XLEN-1];
  assign a_mag = a_neg ? -d_rs1_i : d_rs1_i;
  assign b_mag = b_neg ? -d_rs2_i : d_rs2_i;

  // rst_i is folded in so no stall is requested while reset is asserted.
  assign start = rst_i & (state_q == S_IDLE) & d_valid_i & d_is_divide_i & ~x_kill_i;

`ifdef KMKZ_DIV_FAST_EN
  logic            f_dz, f_ovf, f_lt, fast_hit;
  logic [XLEN-1:0] fast_res;

  assign f_dz     = (d_rs2_i == '0);
  assign f_ovf    = ~d_fun_i[0] & (d_rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (d_rs2_i == '1);
  assign f_lt     = (a_mag < b_mag);
  assign fast_hit = f_dz | f_ovf | f_lt;

  // In every fast case the remainder is either the dividend or zero, and the
  // quotient is all ones, the dividend, or zero.
  always_comb begin
    fast_res = '0;
    if (d_fun_i[1]) begin
      fast_res = f_ovf ? '0 : d_rs1_i;
    end else if (f_dz) begin
      fast_res = '1;
    end else if (f_ovf) begin
      fast_res = d_rs1_i;
    end else begin
      fast_res = '0;
    end
  end
`endif

  // Restoring shift-subtract, STEPS_PER_CYCLE iterations chained per clock.
  // part is one bit wider so the compare sees the bit shifted out of rem.
  always_comb begin
    rem_s = rem_q;
    quo_s = quo_q;
    part  = '0;
    diff  = '0;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      part  = {rem_s, quo_s[XLEN-1]};
      diff  = part - {1'b0, dvs_q};
      quo_s = {quo_s[XLEN-2:0], ~diff[XLEN]};
      rem_s = diff[XLEN] ? part[XLEN-1:0] : diff[XLEN-1:0];
    end
  end

  // Sign fix-up. A zero divisor yields all-ones quotient regardless of sign;
  // the remainder path then restores the original dividend naturally.
  assign q_fin   = dz_q ? '1 : (qneg_q ? -quo_s : quo_s);
  assign r_fin   = rneg_q ? -rem_s : rem_s;
  assign fin_res = rsel_q ? r_fin : q_fin;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    rd_d      = rd_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    dz_d      = dz_q;
    rsel_d    = rsel_q;
    stall_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          stall_req = 1'b1;
          rem_d     = '0;
          quo_d     = a_mag;
          dvs_d     = b_mag;
          qneg_d    = a_neg ^ b_neg;
          rneg_d    = a_neg;
          dz_d      = (d_rs2_i == '0);
          rsel_d    = d_fun_i[1];
          cnt_d     = CW'(N);
          state_d   = S_BUSY;
`ifdef KMKZ_DIV_FAST_EN
          if (fast_hit) begin
            cnt_d   = '0;
            rd_d    = fast_res;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_BUSY: begin
        if (x_kill_i) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          stall_req = 1'b1;
          rem_d     = rem_s;
          quo_d     = quo_s;
          cnt_d     = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            rd_d    = fin_res;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (x_kill_i || !x_stall_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      rd_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      rsel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      rd_q    <= rd_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      rsel_q  <= rsel_d;
    end
  end

  assign x_stall_req_o = stall_req;
  assign x_rd_o        = rd_q;
  assign x_busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_kmkz_divide.sv
// tb/tb_kmkz_divide.sv - randomized self-checking bench for kmkz_divide
module tb_kmkz_divide;

  logic        clk;
  logic        rst_n;
  logic [1:0]  x_stall;
  logic [1:0]  x_kill;
  logic [1:0]  d_valid;
  logic [1:0]  d_isdiv;
  logic [2:0]  fun [2];
  logic [31:0] rs1 [2];
  logic [31:0] rs2 [2];
  logic [1:0]  stall_req;
  logic [31:0] rd [2];
  logic [1:0]  busy;

  logic [31:0] last_res [2];
  int          n_checks;
  int          n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0 retires one bit per clock, instance 1 two bits per clock.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    kmkz_divide #(
      .XLEN           (32),
      .STEPS_PER_CYCLE(g + 1)
    ) u_dut (
      .clk_i        (clk),
      .rst_i        (rst_n),
      .x_stall_i    (x_stall[g]),
      .x_kill_i     (x_kill[g]),
      .d_valid_i    (d_valid[g]),
      .d_is_divide_i(d_isdiv[g]),
      .d_fun_i      (fun[g]),
      .d_rs1_i      (rs1[g]),
      .d_rs2_i      (rs2[g]),
      .x_stall_req_o(stall_req[g]),
      .x_rd_o       (rd[g]),
      .x_busy_o     (busy[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural result of a RISC-V divide, from plain arithmetic.
  function automatic logic [31:0] model_res(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = 32'd0;
    end else if (!f[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return f[1] ? r : q;
  endfunction

  // Number of cycles the execute stage is held for one operation.
  function automatic int model_stall(input int u, input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    int n;
    n = 32 / (u + 1);
`ifdef KMKZ_DIV_FAST_EN
    begin
      logic [31:0] ma, mb;
      ma = (!f[0] && a[31]) ? (32'd0 - a) : a;
      mb = (!f[0] && b[31]) ? (32'd0 - b) : b;
      if (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || ma < mb)
        return 1;
    end
`endif
    return n + 1;
  endfunction

  // Issue one divide on instance u, count stall cycles, check the DONE state.
  // Returns while the DUT sits in DONE (one negedge + 1 into it).
  task automatic run_div(input int u, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input string tag);
    int          cnt;
    logic [31:0] exp;
    exp = model_res(f, a, b);
    @(negedge clk);
    d_valid[u] = 1'b1;
    d_isdiv[u] = 1'b1;
    fun[u]     = f;
    rs1[u]     = a;
    rs2[u]     = b;
    #1;
    cnt = 0;
    while (stall_req[u] && cnt < 100) begin
      cnt++;
      @(negedge clk);
      d_valid[u] = 1'b0;
      #1;
    end
    d_valid[u] = 1'b0;
    check({tag, " stall"}, 32'(cnt), 32'(model_stall(u, f, a, b)));
    check({tag, " busy"}, 32'(busy[u]), 32'd1);
    check({tag, " rd"}, rd[u], exp);
    last_res[u] = exp;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    x_stall  = '0;
    x_kill   = '0;
    d_valid  = 2'b11;
    d_isdiv  = 2'b11;
    for (int i = 0; i < 2; i++) begin
      fun[i]      = 3'b101;
      rs1[i]      = 32'd1;
      rs2[i]      = 32'd1;
      last_res[i] = 32'd0;
    end

    // Reset state, including no stall request while a divide is offered.
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst%0d busy", i), 32'(busy[i]), 32'd0);
      check($sformatf("rst%0d stall", i), 32'(stall_req[i]), 32'd0);
      check($sformatf("rst%0d rd", i), rd[i], 32'd0);
    end
    d_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Valid without is_divide must not start.
    @(negedge clk);
    d_valid[0] = 1'b1;
    d_isdiv[0] = 1'b0;
    #1;
    check("not_divide stall", 32'(stall_req[0]), 32'd0);
    d_valid[0] = 1'b0;
    d_isdiv[0] = 1'b1;

    // Directed cases on the one-bit-per-clock instance.
    run_div(0, 3'b101, 32'd100, 32'd7, "divu_100_7");
    run_div(0, 3'b111, 32'd100, 32'd7, "remu_100_7");
    run_div(0, 3'b100, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_div(0, 3'b110, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    run_div(0, 3'b110, 32'd7, 32'hFFFF_FFFE, "rem_7_m2");
    run_div(0, 3'b101, 32'd5, 32'd0, "divu_5_0");
    run_div(0, 3'b111, 32'd5, 32'd0, "remu_5_0");
    run_div(0, 3'b100, 32'hFFFF_FFF9, 32'd0, "div_m7_0");
    run_div(0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_div(0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");

    // Kill in BUSY cycle 10: back to IDLE, result register untouched.
    @(negedge clk);
    d_valid[0] = 1'b1;
    fun[0]     = 3'b101;
    rs1[0]     = 32'd1000;
    rs2[0]     = 32'd3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      d_valid[0] = 1'b0;
    end
    x_kill[0] = 1'b1;
    #1;
    check("kill stall", 32'(stall_req[0]), 32'd0);
    @(negedge clk);
    x_kill[0] = 1'b0;
    #1;
    check("kill busy", 32'(busy[0]), 32'd0);
    check("kill stall_after", 32'(stall_req[0]), 32'd0);
    check("kill rd", rd[0], last_res[0]);
    run_div(0, 3'b101, 32'd9, 32'd3, "divu_9_3");

    // Two-bit instance: hold DONE with x_stall for three cycles.
    x_stall[1] = 1'b1;
    run_div(1, 3'b101, 32'hFFFF_FFFF, 32'h10, "s2_divu");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("hold%0d rd", i), rd[1], 32'h0FFF_FFFF);
      check($sformatf("hold%0d busy", i), 32'(busy[1]), 32'd1);
      check($sformatf("hold%0d stall", i), 32'(stall_req[1]), 32'd0);
    end
    x_stall[1] = 1'b0;
    @(negedge clk);
    #1;
    check("hold release busy", 32'(busy[1]), 32'd0);

    // Randomized operations on both instances.
    for (int n = 0; n < 60; n++) begin
      int          u;
      logic [2:0]  f;
      logic [31:0] a, b;
      u = n % 2;
      f = 3'(4 + $urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: ;
        1: begin a = $urandom_range(0, 255); b = $urandom_range(1, 15); end
        2: b = 32'd0;
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4: begin a = $urandom_range(0, 100); b = b | 32'h0000_1000; end
        default: b = $urandom_range(1, 9) | ($urandom_range(0, 1) ? 32'hFFFF_FFF0 : 32'd0);
      endcase
      run_div(u, f, a, b, $sformatf("rnd%0d f%0d %h/%h", n, f, a, b));
    end

    // Reset in BUSY cycle 5 clears outputs immediately; nothing appears later.
    @(negedge clk);
    d_valid[0] = 1'b1;
    fun[0]     = 3'b100;
    rs1[0]     = 32'h7FFF_FFFF;
    rs2[0]     = 32'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      d_valid[0] = 1'b0;
    end
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst busy", 32'(busy[0]), 32'd0);
    check("mid_rst stall", 32'(stall_req[0]), 32'd0);
    check("mid_rst rd", rd[0], 32'd0);
    check("mid_rst rd1", rd[1], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("post_rst busy", 32'(busy[0]), 32'd0);
    check("post_rst rd", rd[0], 32'd0);
    run_div(0, 3'b100, 32'd20, 32'hFFFF_FFFC, "div_20_m4");

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
